// File: rtl/lsu_rmw_if.sv
// lsu_rmw_if: bus bundle between the pipeline MEM stage, the lsu_rmw block
// and the word-addressed data memory.
//   slave  : the lsu_rmw side (takes requests, drives the memory port)
//   master : the pipeline + memory side (issues requests, returns dm_rdata)
// Request  : req_valid/req_ready handshake, req_we, req_size, req_sext,
//            req_addr, req_wdata, req_pc
// Response : resp_valid pulse with resp_rdata / resp_err
// Memory   : dm_addr, dm_wdata, dm_we, dm_pc out; dm_rdata back (combinational)
interface lsu_rmw_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_sext;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] req_pc;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_we;
   logic [31:0] dm_pc;
   logic [31:0] dm_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata, req_pc,
      output req_ready,
      output resp_valid, resp_rdata, resp_err,
      output dm_addr, dm_wdata, dm_we, dm_pc,
      input  dm_rdata
   );

   modport master (
      output req_valid, req_we, req_size, req_sext, req_addr, req_wdata, req_pc,
      input  req_ready,
      input  resp_valid, resp_rdata, resp_err,
      input  dm_addr, dm_wdata, dm_we, dm_pc,
      output dm_rdata
   );
endinterface

// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store initiator between the MEM stage and a word-only data
// memory. Byte/half/word loads with sign or zero extension; sub-word stores
// are done as read-modify-write of the whole word. Misaligned and
// out-of-range requests complete with resp_err and never write memory.
// Ports:
//   clk   : clock, all state on posedge
//   reset : asynchronous, active-low
//   bus   : lsu_rmw_if.slave (request, response and memory port)
// Optional build macro LSU_TRACE_EN: prints a line per memory write and
// per faulting request. Without it the logic is identical and silent.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request, req_ready=1
// RD    | memory word on dm_rdata; load lane extract or store merge
// WR    | dm_we=1 for this single cycle, memory captures on exit edge
// DONE  | resp_valid=1 for one cycle, response regs cleared on exit
module lsu_rmw #(
   parameter int unsigned DEPTH_WORDS = 3072,
   parameter int unsigned IDX_W       = 12
) (
   input logic       clk,
   input logic       reset,
   lsu_rmw_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t      state, state_nxt;

   logic        we_q;
   logic [1:0]  size_q;
   logic        sext_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] pc_q;
   logic [31:0] dm_wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        misaligned;
   logic        out_of_range;
   logic        req_err;
   logic [4:0]  lane_sh;
   logic [31:0] lane_data;
   logic [31:0] ld_data;
   logic [31:0] merge_mask;
   logic [31:0] merged;

   always_comb begin
      misaligned = 1'b0;
      case (bus.req_size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = bus.req_addr[0];
         2'b10:   misaligned = (bus.req_addr[1:0] != 2'b00);
         default: misaligned = 1'b1;
      endcase
   end

   // Index beyond IDX_W bits is always out of range; within it compare to depth.
   assign out_of_range = (bus.req_addr[31:IDX_W+2] != '0) ||
                         (32'(bus.req_addr[IDX_W+1:2]) >= DEPTH_WORDS);
   assign req_err      = misaligned || out_of_range;

   // Lane offset in bits; half accesses are aligned so addr[0] is 0 there.
   assign lane_sh   = {addr_q[1:0], 3'b000};
   assign lane_data = bus.dm_rdata >> lane_sh;

   always_comb begin
      ld_data = lane_data;
      case (size_q)
         2'b00:   ld_data = sext_q ? {{24{lane_data[7]}}, lane_data[7:0]}
                                   : {24'h0, lane_data[7:0]};
         2'b01:   ld_data = sext_q ? {{16{lane_data[15]}}, lane_data[15:0]}
                                   : {16'h0, lane_data[15:0]};
         default: ld_data = lane_data;
      endcase
   end

   always_comb begin
      merge_mask = 32'h0;
      merged     = wdata_q;
      case (size_q)
         2'b00: begin
            merge_mask = 32'h0000_00FF << lane_sh;
            merged     = (bus.dm_rdata & ~merge_mask) |
                         ({24'h0, wdata_q[7:0]} << lane_sh);
         end
         2'b01: begin
            merge_mask = 32'h0000_FFFF << lane_sh;
            merged     = (bus.dm_rdata & ~merge_mask) |
                         ({16'h0, wdata_q[15:0]} << lane_sh);
         end
         default: begin
            merge_mask = 32'h0;
            merged     = wdata_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.dm_we      = 1'b0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               if (req_err)                                  state_nxt = DONE;
               else if (bus.req_we && bus.req_size == 2'b10) state_nxt = WR;
               else                                          state_nxt = RD;
            end
         end
         RD:   state_nxt = we_q ? WR : DONE;
         WR: begin
            bus.dm_we = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            bus.resp_valid = 1'b1;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_q       <= 1'b0;
         size_q     <= 2'b00;
         sext_q     <= 1'b0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         pc_q       <= 32'h0;
         dm_wdata_q <= 32'h0;
         rdata_q    <= 32'h0;
         err_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  we_q    <= bus.req_we;
                  size_q  <= bus.req_size;
                  sext_q  <= bus.req_sext;
                  addr_q  <= bus.req_addr;
                  wdata_q <= bus.req_wdata;
                  pc_q    <= bus.req_pc;
                  err_q   <= req_err;
                  if (!req_err && bus.req_we && bus.req_size == 2'b10)
                     dm_wdata_q <= bus.req_wdata;
               end
            end
            RD: begin
               if (we_q) dm_wdata_q <= merged;
               else      rdata_q    <= ld_data;
            end
            DONE: begin
               rdata_q <= 32'h0;
               err_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.dm_addr    = {addr_q[31:2], 2'b00};
   assign bus.dm_wdata   = dm_wdata_q;
   assign bus.dm_pc      = pc_q;
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

`ifdef LSU_TRACE_EN
   always @(posedge clk) begin
      if (reset && state == WR)
         $display("@%h: *%h <= %h", pc_q, {addr_q[31:2], 2'b00}, dm_wdata_q);
      if (reset && state == IDLE && bus.req_valid && req_err)
         $display("@%h: LSU fault %h", bus.req_pc, bus.req_addr);
   end
`else
`endif

endmodule

// File: tb/tb_lsu_rmw.sv
// tb_lsu_rmw: directed bench for lsu_rmw with a byte-level reference memory
// model, a per-cycle compare process and literal expectations per request.
module tb_lsu_rmw;
   localparam int DEPTH = 3072;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   lsu_rmw_if bus();

   lsu_rmw #(.DEPTH_WORDS(DEPTH), .IDX_W(12)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Environment memory seen by the DUT.
   logic [31:0] dm_mem [0:DEPTH-1];
   assign bus.dm_rdata = (bus.dm_addr[31:2] < 30'(DEPTH)) ? dm_mem[bus.dm_addr[13:2]] : 32'h0;
   always @(posedge clk) if (bus.dm_we) dm_mem[bus.dm_addr[13:2]] <= bus.dm_wdata;

   int n_vec = 0;
   int n_mis = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: byte-addressed little-endian memory and request timing.
   logic [7:0]  mb [0:4*DEPTH-1];
   int          cyc = 0, acc = 0, m_lat = 0, idle_from = 0;
   bit          pend = 0, m_wr = 0, m_err = 0;
   logic [31:0] m_rdata = 0, m_waddr = 0, m_wdata = 0, m_pc = 0;

   always @(posedge clk or negedge reset) begin : model
      logic [31:0] a, val, w;
      int          n, off;
      if (!reset) begin
         pend      = 0;
         m_wr      = 0;
         idle_from = 0;
      end else begin
         cyc++;
         if (pend && m_wr && cyc == acc + m_lat - 1)
            for (int j = 0; j < 4; j++) mb[int'(m_waddr) + j] = m_wdata[8*j +: 8];
         if (pend && cyc >= idle_from) pend = 0;
         if (bus.req_valid && (cyc - 1) >= idle_from) begin
            a       = bus.req_addr;
            acc     = cyc;
            pend    = 1;
            m_pc    = bus.req_pc;
            m_rdata = 0;
            m_wr    = 0;
            n       = (bus.req_size == 2'b11) ? 0 : (1 << bus.req_size);
            if (n == 0) m_err = 1;
            else        m_err = ((a % n) != 0) || ((a >> 2) >= DEPTH);
            if (m_err) m_lat = 1;
            else if (bus.req_we) begin
               m_lat   = (n == 4) ? 2 : 3;
               m_wr    = 1;
               m_waddr = a & ~32'h3;
               off     = int'(a[1:0]);
               w       = 0;
               for (int j = 0; j < 4; j++) begin
                  if (j >= off && j < off + n) w[8*j +: 8] = bus.req_wdata[8*(j-off) +: 8];
                  else                         w[8*j +: 8] = mb[int'(m_waddr) + j];
               end
               m_wdata = w;
            end else begin
               m_lat = 2;
               val   = 0;
               for (int i = 0; i < n; i++) val[8*i +: 8] = mb[int'(a) + i];
               if (bus.req_sext && n < 4 && val[8*n-1])
                  for (int i = n; i < 4; i++) val[8*i +: 8] = 8'hFF;
               m_rdata = val;
            end
            idle_from = acc + m_lat;
         end
      end
   end

   always @(negedge clk) begin : compare
      bit ev, ew;
      ev = pend && (cyc == acc + m_lat - 1);
      ew = pend && m_wr && (cyc == acc + m_lat - 2);
      chk("req_ready", {31'h0, bus.req_ready}, {31'h0, !pend});
      chk("resp_valid", {31'h0, bus.resp_valid}, {31'h0, ev});
      chk("dm_we", {31'h0, bus.dm_we}, {31'h0, ew});
      if (ev) begin
         chk("resp_rdata", bus.resp_rdata, m_rdata);
         chk("resp_err", {31'h0, bus.resp_err}, {31'h0, m_err});
      end
      if (ew) begin
         chk("dm_addr", bus.dm_addr, m_waddr);
         chk("dm_wdata", bus.dm_wdata, m_wdata);
         chk("dm_pc", bus.dm_pc, m_pc);
      end
   end

   int          resp_cnt = 0, we_cnt = 0;
   logic [31:0] last_waddr = 0, last_wdata = 0;
   always @(negedge clk) begin : monitor
      if (bus.resp_valid) resp_cnt++;
      if (bus.dm_we) begin
         we_cnt++;
         last_waddr = bus.dm_addr;
         last_wdata = bus.dm_wdata;
      end
   end

   logic [31:0] last_rdata;
   logic        last_err;
   int          last_lat;

   task automatic set_req(input bit we, input bit [1:0] size, input bit sext,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] pc);
      bus.req_we    = we;
      bus.req_size  = size;
      bus.req_sext  = sext;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_pc    = pc;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) chk("accept_timeout", {31'h0, bus.req_ready}, 32'h1);
   endtask

   task automatic issue(input bit we, input bit [1:0] size, input bit sext,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] pc);
      int lat;
      @(negedge clk);
      set_req(we, size, sext, addr, wdata, pc);
      bus.req_valid = 1'b1;
      wait_ready();
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.resp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.resp_valid) chk("resp_timeout", {31'h0, bus.resp_valid}, 32'h1);
      last_rdata = bus.resp_rdata;
      last_err   = bus.resp_err;
      last_lat   = lat;
      #1;
   endtask

   task automatic b2b_set(input int k);
      case (k)
         0: set_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 32'h400);
         1: set_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h00000077, 32'h404);
         2: set_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h408);
         default: set_req(1'b0, 2'b01, 1'b1, 32'h01, 32'h0, 32'h40C);
      endcase
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int w0, r0, rdy;
      for (int i = 0; i < DEPTH; i++) dm_mem[i] = 32'h0;
      for (int i = 0; i < 4*DEPTH; i++) mb[i] = 8'h0;
      bus.req_valid = 1'b0;
      set_req(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
      reset = 1'b0;

      #1;
      chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
      chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
      chk("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
      chk("rst_dm_we", {31'h0, bus.dm_we}, 32'h0);
      chk("rst_dm_addr", bus.dm_addr, 32'h0);
      chk("rst_dm_wdata", bus.dm_wdata, 32'h0);
      chk("rst_dm_pc", bus.dm_pc, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // word store then word load
      w0 = we_cnt;
      issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h100);
      chk("sw_lat", last_lat, 2);
      chk("sw_err", {31'h0, last_err}, 32'h0);
      chk("sw_waddr", last_waddr, 32'h10);
      chk("sw_wdata", last_wdata, 32'hDEADBEEF);
      chk("sw_we_pulses", we_cnt - w0, 1);
      issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h104);
      chk("lw_lat", last_lat, 2);
      chk("lw_rdata", last_rdata, 32'hDEADBEEF);
      chk("lw_err", {31'h0, last_err}, 32'h0);

      // byte store read-modify-write
      issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h108);
      w0 = we_cnt;
      issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA, 32'h10C);
      chk("sb_lat", last_lat, 3);
      chk("sb_wdata", last_wdata, 32'h11AA3344);
      chk("sb_we_pulses", we_cnt - w0, 1);

      // sign / zero extension
      issue(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 32'h110);
      chk("lb_sext", last_rdata, 32'hFFFFFFAA);
      issue(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'h114);
      chk("lbu", last_rdata, 32'h000000AA);
      issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h118);
      chk("lh_sext_pos", last_rdata, 32'h000011AA);

      // errors
      w0 = we_cnt;
      issue(1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 32'h11C);
      chk("lh_mis_err", {31'h0, last_err}, 32'h1);
      chk("lh_mis_lat", last_lat, 1);
      chk("lh_mis_rdata", last_rdata, 32'h0);
      issue(1'b1, 2'b10, 1'b0, 32'h00003000, 32'h12345678, 32'h120);
      chk("sw_range_err", {31'h0, last_err}, 32'h1);
      chk("sw_range_lat", last_lat, 1);
      issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h124);
      chk("size11_err", {31'h0, last_err}, 32'h1);
      issue(1'b1, 2'b01, 1'b0, 32'h0FFF_FFF0, 32'h1, 32'h128);
      chk("sh_range_err", {31'h0, last_err}, 32'h1);
      chk("err_no_write", we_cnt - w0, 0);
      chk("mem_after_err", dm_mem[4], 32'h11AA3344);

      // half store, then half and byte loads around it
      issue(1'b1, 2'b01, 1'b0, 32'h10, 32'h1234BEEF, 32'h12C);
      chk("sh_lat", last_lat, 3);
      chk("sh_wdata", last_wdata, 32'h11AABEEF);
      issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h130);
      chk("lh_sext_neg", last_rdata, 32'hFFFFBEEF);
      issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h134);
      chk("lb_lane3", last_rdata, 32'h00000011);

      // reset while the read-modify-write is in RD
      w0 = we_cnt;
      @(negedge clk);
      set_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055, 32'h200);
      bus.req_valid = 1'b1;
      wait_ready();
      @(posedge clk);
      #2;
      reset = 1'b0;
      bus.req_valid = 1'b0;
      #1;
      chk("mid_rst_dm_we", {31'h0, bus.dm_we}, 32'h0);
      chk("mid_rst_ready", {31'h0, bus.req_ready}, 32'h1);
      r0 = resp_cnt;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      chk("mid_rst_no_resp", resp_cnt - r0, 0);
      chk("mid_rst_no_write", we_cnt - w0, 0);
      chk("mid_rst_mem", dm_mem[4], 32'h11AABEEF);
      issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h204);
      chk("mid_rst_reload", last_rdata, 32'h11AABEEF);

      // back-to-back with req_valid held high
      w0  = we_cnt;
      r0  = resp_cnt;
      rdy = 0;
      @(negedge clk);
      b2b_set(0);
      bus.req_valid = 1'b1;
      wait_ready();
      @(posedge clk);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         b2b_set(k);
         wait_ready();
         if (bus.req_ready) rdy++;
         @(posedge clk);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      chk("b2b_resps", resp_cnt - r0, 4);
      chk("b2b_we_pulses", we_cnt - w0, 2);
      chk("b2b_ready_pulses", rdy, 3);
      issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h410);
      chk("b2b_mem", last_rdata, 32'hCAFE770D);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store initiator that sits between the pipeline MEM stage and the word-addressed data memory.
- The data memory offers only whole-word combinational reads and whole-word clocked writes.
- This block provides byte, halfword and word loads with sign or zero extension.
- Sub-word stores are done as read-modify-write: the block reads the word, merges the new bytes, then writes the full word back. It also flags misaligned and out-of-range accesses.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words in data memory; word index >= DEPTH_WORDS is out of range.
- IDX_W, 12, word-index width taken from addr[IDX_W+1:2].

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low.
- req_valid  in  1  pipeline presents an access.
- req_ready  out  1  block accepts; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal (treated as misaligned).
- req_sext  in  1  loads: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_pc  in  32  PC of the instruction, passed through for logging.
- resp_valid  out  1  one-cycle pulse; access complete.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or out-of-range; valid with resp_valid.
- dm_addr  out  32  word-aligned byte address to memory (low 2 bits 0).
- dm_wdata  out  32  full word to write.
- dm_we  out  1  memory write enable.
- dm_pc  out  32  latched req_pc, for the memory's write log.
- dm_rdata  in  32  combinational read data for dm_addr.

Behaviour:
- States: IDLE, RD, WR, DONE. Reset value is IDLE.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, dm_we=0, dm_addr=0, dm_wdata=0, dm_pc=0. All internal latches are 0.
- IDLE: req_ready=1. On posedge with req_valid=1:
  - Latch we, size, sext, addr, wdata and pc.
  - Check alignment (half needs addr[0]=0, word needs addr[1:0]=0, size 11 is always bad) and range (addr[31:2] >= DEPTH_WORDS).
  - On error: go to DONE with resp_err=1; the memory is never written.
  - Word store: go to WR with dm_wdata=req_wdata.
  - Any other valid access: go to RD.
- RD:
  - dm_addr = {latched addr[31:2], 2'b00}, dm_we=0.
  - Load: at posedge, select the lane (byte lane = addr[1:0], half lane = addr[1]), extend per sext, register into resp_rdata, go to DONE.
  - Sub-word store: at posedge, merge req_wdata[7:0] or [15:0] into the addressed lane of dm_rdata, keep the other bytes, register into dm_wdata, go to WR.
- WR: dm_we=1 for exactly this one cycle. The memory captures the write on the posedge leaving WR. Go to DONE.
- DONE: resp_valid=1 for one cycle, req_ready=0. Next state is IDLE. resp_rdata and resp_err are cleared on the following posedge.
- Latencies, counted from the accept edge to resp_valid high:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- dm_we is asserted only in WR, never more than one cycle per request, and never for an error.
- No new request is accepted until back in IDLE. req_valid outside IDLE is ignored.
- Reset asserted mid-operation: state returns to IDLE immediately (asynchronously) and dm_we drops at once. A pending write is dropped, not completed. No resp_valid is produced for the aborted request.
- Big-endian lane numbering is not used: byte lane 0 = bits [7:0].

Optional Feature:
- Macro LSU_TRACE_EN.
- Defined: on each WR-exit posedge, $display("@%h: *%h <= %h", pc, byte addr, merged word). On each error, $display("@%h: LSU fault %h", pc, addr).
- Undefined: no $display; the logic is otherwise identical.

Test Plan:
- Word store then load: store addr=0x00000010, wdata=0xDEADBEEF, size=10 → dm_we high for 1 cycle, dm_addr=0x10, dm_wdata=0xDEADBEEF. A following word load returns resp_rdata=0xDEADBEEF, resp_err=0.
- Byte store read-modify-write: memory word 0x10 holds 0x11223344; store byte addr=0x12, wdata=0x000000AA → dm_wdata=0x11AA3344, resp_valid 3 cycles after accept.
- Sign/zero-extend loads: with 0x11AA3344 at 0x10, byte load addr=0x12 sext=1 → 0xFFFFFFAA; sext=0 → 0x000000AA. Half load addr=0x12 sext=1 → 0x000011AA.
- Misaligned and range errors: half load addr=0x13 → resp_err=1 after 1 cycle, dm_we never high. Word store addr=0x00003000 (index 3072) → resp_err=1, memory unchanged.
- Reset mid-RMW: byte store accepted, reset driven low while in RD → dm_we stays 0, state is IDLE, req_ready=1 immediately, memory word unchanged.
- Back-to-back: req_valid held high continuously → req_ready pulses once per completed request; exactly one dm_we pulse per store.
